// File: rtl/rrv64_generic_ram_req.sv
// ----------------------------------------------------------------------------
// rrv64_generic_ram_req
//
// Initiator side of a single-port generic RAM (cs / per-bit we / addr / wd in,
// registered rd out). Requests arrive on a valid/ready port and each accepted
// request becomes exactly one RAM access in the same cycle. Reads are tracked
// through a RD_LATENCY-deep valid pipe. At the tail of that pipe the RAM read
// data is captured into a response FIFO, which is drained in order through a
// second valid/ready port.
//
// After reset, with INIT_EN=1, the block first sweeps every RAM word with
// INIT_VALUE and accepts no request until the sweep is done.
//
// Handshake rule (both ports): a transfer happens on a rising clk edge where
// valid and ready are both high. Once valid is raised, the payload stays
// stable until that transfer. ready never depends combinationally on valid.
// Neither ready output depends on the opposite port's valid or ready input.
//
// Ports
//   clk            clock, every state update on the rising edge
//   rst_n          synchronous reset, active low
//   req_valid_i    request valid
//   req_ready_o    request accepted when valid & ready
//   req_addr_i     word address
//   req_wdata_i    write data
//   req_wmask_i    per-bit write enable, all-zero means read
//   resp_valid_o   read data valid (response FIFO non-empty)
//   resp_ready_i   response consumed when valid & ready
//   resp_rdata_o   read data at the FIFO head
//   init_done_o    high once the controller is in RUN
//   ram_cs_o       RAM chip select
//   ram_we_o       RAM per-bit write enable
//   ram_addr_o     RAM address
//   ram_wd_o       RAM write data
//   ram_rd_i       RAM read data, valid RD_LATENCY cycles after the cs edge
//   dbg_state_o    controller state (0 = INIT sweep, 1 = RUN)
// ----------------------------------------------------------------------------
module rrv64_generic_ram_req #(
    parameter int                      ADDR_BITS  = 4,
    parameter int                      DATA_BITS  = 8,
    parameter int                      RD_LATENCY = 1,
    parameter int                      RESP_DEPTH = 4,
    parameter bit                      INIT_EN    = 1'b1,
    parameter logic [DATA_BITS-1:0]    INIT_VALUE = '0
) (
    input  logic                    clk,
    input  logic                    rst_n,

    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic [ADDR_BITS-1:0]    req_addr_i,
    input  logic [DATA_BITS-1:0]    req_wdata_i,
    input  logic [DATA_BITS-1:0]    req_wmask_i,

    output logic                    resp_valid_o,
    input  logic                    resp_ready_i,
    output logic [DATA_BITS-1:0]    resp_rdata_o,

    output logic                    init_done_o,

    output logic                    ram_cs_o,
    output logic [DATA_BITS-1:0]    ram_we_o,
    output logic [ADDR_BITS-1:0]    ram_addr_o,
    output logic [DATA_BITS-1:0]    ram_wd_o,
    input  logic [DATA_BITS-1:0]    ram_rd_i,

    output logic                    dbg_state_o
);

    // ------------------------------------------------------------------------
    // Local sizing
    // ------------------------------------------------------------------------
    localparam int CNT_W = $clog2(RESP_DEPTH + 1);
    localparam int PTR_W = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;

    localparam logic [ADDR_BITS-1:0] SWEEP_LAST = {ADDR_BITS{1'b1}};
    localparam logic [CNT_W-1:0]     DEPTH_CNT  = CNT_W'(RESP_DEPTH);
    localparam logic [CNT_W-1:0]     CNT_ONE    = CNT_W'(1);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // ------------------------------------------------------------------------
    // Controller state
    // ------------------------------------------------------------------------
    state_t                  state;
    logic [ADDR_BITS-1:0]    sweep_cnt;
    logic                    init_done_q;

    // Request / response bookkeeping
    logic [CNT_W-1:0]        credit_cnt;   // reads in flight + FIFO occupancy
    logic [RD_LATENCY-1:0]   rd_pipe;      // one bit per read in the latency pipe
    logic [DATA_BITS-1:0]    fifo_mem [RESP_DEPTH];
    logic [PTR_W-1:0]        wr_ptr;
    logic [PTR_W-1:0]        rd_ptr;
    logic [CNT_W-1:0]        fifo_cnt;

    logic                    accept;
    logic                    rd_accept;
    logic                    push;
    logic                    pop;

    // Pointer increment that wraps modulo RESP_DEPTH, so non-power-of-two
    // depths work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(RESP_DEPTH - 1)) begin
            return '0;
        end
        return p + PTR_W'(1);
    endfunction

    // ------------------------------------------------------------------------
    // FSM: INIT sweeps addresses 0..2**ADDR_BITS-1, one per cycle, then RUN.
    // init_done is registered and is set on the same edge that enters RUN.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= INIT_EN ? ST_INIT : ST_RUN;
            sweep_cnt   <= '0;
            init_done_q <= 1'b0;
        end else begin
            case (state)
                ST_INIT: begin
                    sweep_cnt <= sweep_cnt + ADDR_BITS'(1);
                    if (sweep_cnt == SWEEP_LAST) begin
                        state       <= ST_RUN;
                        init_done_q <= 1'b1;
                    end
                end
                ST_RUN: begin
                    init_done_q <= 1'b1;
                end
                default: begin
                    state <= ST_INIT;
                end
            endcase
        end
    end

    assign init_done_o = init_done_q;
    assign dbg_state_o = (state == ST_RUN);

    // ------------------------------------------------------------------------
    // Request acceptance.
    // ready is driven only from registers, plus the rst_n gate. The gate
    // keeps the port quiet while reset is held.
    // ------------------------------------------------------------------------
    assign req_ready_o = rst_n && (state == ST_RUN) && (credit_cnt < DEPTH_CNT);
    assign accept      = req_valid_i && req_ready_o;
    assign rd_accept   = accept && (req_wmask_i == '0);

    // ------------------------------------------------------------------------
    // RAM drive.
    // During the sweep, the RAM is written with a full mask.
    // In RUN, an accepted request goes straight to the RAM pins in the same
    // cycle.
    // Everything is zero otherwise, including while reset is asserted.
    // ------------------------------------------------------------------------
    always_comb begin
        ram_cs_o   = 1'b0;
        ram_we_o   = '0;
        ram_addr_o = '0;
        ram_wd_o   = '0;
        if (rst_n && (state == ST_INIT)) begin
            ram_cs_o   = 1'b1;
            ram_we_o   = '1;
            ram_addr_o = sweep_cnt;
            ram_wd_o   = INIT_VALUE;
        end else if (accept) begin
            ram_cs_o   = 1'b1;
            ram_we_o   = req_wmask_i;
            ram_addr_o = req_addr_i;
            ram_wd_o   = req_wdata_i;
        end
    end

    // ------------------------------------------------------------------------
    // Read latency pipe.
    // A read accepted in cycle T reaches the top bit in cycle T+RD_LATENCY.
    // That is the cycle in which ram_rd_i carries its data.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_pipe <= '0;
        end else begin
            rd_pipe <= (rd_pipe << 1) | RD_LATENCY'(rd_accept);
        end
    end

    assign push = rd_pipe[RD_LATENCY-1];

    // ------------------------------------------------------------------------
    // Response FIFO.
    // The credit check at issue guarantees that a push always finds a free
    // entry. Push and pop may happen in the same cycle.
    // ------------------------------------------------------------------------
    assign resp_valid_o = rst_n && (fifo_cnt != '0);
    assign pop          = resp_valid_o && resp_ready_i;
    assign resp_rdata_o = resp_valid_o ? fifo_mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= ram_rd_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + CNT_ONE;
                2'b01:   fifo_cnt <= fifo_cnt - CNT_ONE;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Credits.
    // A credit is reserved when a read is accepted and returned when its
    // response is popped. This bounds reads in flight plus FIFO occupancy by
    // RESP_DEPTH.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            credit_cnt <= '0;
        end else begin
            case ({rd_accept, pop})
                2'b10:   credit_cnt <= credit_cnt + CNT_ONE;
                2'b01:   credit_cnt <= credit_cnt - CNT_ONE;
                default: credit_cnt <= credit_cnt;
            endcase
        end
    end

    // Structural invariants of the credit scheme.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (credit_cnt <= DEPTH_CNT);
            assert (!(push && !pop && (fifo_cnt == DEPTH_CNT)));
        end
    end

endmodule

// File: tb/tb_rrv64_generic_ram_req.sv
module tb_rrv64_generic_ram_req;

  localparam int AB = 4;
  localparam int DB = 8;
  localparam int RL = 1;
  localparam int RD = 4;
  localparam int NW = 1 << AB;
  localparam logic [DB-1:0] INIT_V = 8'h00;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          req_valid, req_ready;
  logic [AB-1:0] req_addr;
  logic [DB-1:0] req_wdata, req_wmask;
  logic          resp_valid, resp_ready;
  logic [DB-1:0] resp_rdata;
  logic          init_done;
  logic          ram_cs;
  logic [DB-1:0] ram_we, ram_wd, ram_rd;
  logic [AB-1:0] ram_addr;
  logic          dbg_state;

  rrv64_generic_ram_req #(
    .ADDR_BITS(AB), .DATA_BITS(DB), .RD_LATENCY(RL), .RESP_DEPTH(RD),
    .INIT_EN(1'b1), .INIT_VALUE(INIT_V)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_addr_i(req_addr),
    .req_wdata_i(req_wdata), .req_wmask_i(req_wmask),
    .resp_valid_o(resp_valid), .resp_ready_i(resp_ready), .resp_rdata_o(resp_rdata),
    .init_done_o(init_done),
    .ram_cs_o(ram_cs), .ram_we_o(ram_we), .ram_addr_o(ram_addr), .ram_wd_o(ram_wd),
    .ram_rd_i(ram_rd), .dbg_state_o(dbg_state)
  );

  // ---------------- RAM behavioural model (one-cycle registered read) ----------------
  logic [DB-1:0] ram_mem [NW];
  logic [DB-1:0] ram_rd_q;
  always @(posedge clk) begin
    if (ram_cs) begin
      ram_rd_q <= ram_mem[ram_addr];
      ram_mem[ram_addr] <= (ram_mem[ram_addr] & ~ram_we) | (ram_wd & ram_we);
    end
  end
  assign ram_rd = ram_rd_q;

  // ---------------- scoreboard state ----------------
  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int pop_cnt = 0;
  bit mon_en = 1'b0;
  bit rand_rr = 1'b0;
  logic [DB-1:0] shadow [NW];
  logic [DB-1:0] exp_q[$];
  int pop_cyc_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (rand_rr) begin
      #1 resp_ready = 1'($urandom_range(0, 1));
    end
  end

  // Monitor: the bench's view of the protocol, checked every cycle in RUN.
  always @(negedge clk) begin
    if (mon_en) begin
      n_cmp++;
      if (req_ready !== (exp_q.size() < RD)) begin
        n_fail++;
        $display("FAIL mon_ready: got %b expected %b (outstanding %0d)", req_ready, (exp_q.size() < RD), exp_q.size());
      end
      n_cmp++;
      if (init_done !== 1'b1 || dbg_state !== 1'b1) begin
        n_fail++;
        $display("FAIL mon_run: init_done %b dbg_state %b expected 1 1", init_done, dbg_state);
      end
      if (req_valid && req_ready) begin
        n_cmp++;
        if (ram_cs !== 1'b1 || ram_addr !== req_addr || ram_we !== req_wmask || ram_wd !== req_wdata) begin
          n_fail++;
          $display("FAIL mon_issue: cs %b addr %h we %h wd %h expected 1 %h %h %h",
                   ram_cs, ram_addr, ram_we, ram_wd, req_addr, req_wmask, req_wdata);
        end
        if (req_wmask == '0) exp_q.push_back(shadow[req_addr]);
        else shadow[req_addr] = (shadow[req_addr] & ~req_wmask) | (req_wdata & req_wmask);
      end else begin
        n_cmp++;
        if (ram_cs !== 1'b0 || ram_we !== '0) begin
          n_fail++;
          $display("FAIL mon_idle: cs %b we %h expected 0 00", ram_cs, ram_we);
        end
      end
      if (resp_valid && resp_ready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL mon_resp: got unexpected response %h expected none", resp_rdata);
        end else begin
          logic [DB-1:0] e;
          e = exp_q.pop_front();
          if (resp_rdata !== e) begin
            n_fail++;
            $display("FAIL mon_resp: got %h expected %h", resp_rdata, e);
          end
        end
        pop_cnt++;
        pop_cyc_q.push_back(cyc);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_req(input logic [AB-1:0] a, input logic [DB-1:0] d,
                        input logic [DB-1:0] m, output int acc_cyc);
    bit got;
    int tries;
    got = 1'b0;
    tries = 0;
    acc_cyc = -1;
    req_valid = 1'b1; req_addr = a; req_wdata = d; req_wmask = m;
    while (!got && tries < 60) begin
      @(negedge clk);
      if (req_ready) begin
        got = 1'b1;
        acc_cyc = cyc;
      end
      @(posedge clk); #1;
      tries++;
    end
    req_valid = 1'b0;
    if (!got) begin
      n_cmp++; n_fail++;
      $display("FAIL req_timeout: got no accept expected accept for addr %h", a);
    end
  endtask

  task automatic wait_drain(input string nm);
    int i;
    i = 0;
    while (exp_q.size() != 0 && i < 300) begin
      @(posedge clk);
      i++;
    end
    #1;
    if (exp_q.size() != 0) begin
      n_cmp++; n_fail++;
      $display("FAIL %s_drain: got %0d pending expected 0", nm, exp_q.size());
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0; req_valid = 1'b0; resp_ready = 1'b0;
    req_addr = '0; req_wdata = '0; req_wmask = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (ram_cs !== 1'b0 || req_ready !== 1'b0 || resp_valid !== 1'b0 || init_done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: cs %b ready %b rvalid %b done %b expected 0 0 0 0",
               ram_cs, req_ready, resp_valid, init_done);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < NW; i++) begin
      @(negedge clk);
      n_cmp++;
      if (ram_cs !== 1'b1 || ram_we !== 8'hFF || ram_wd !== INIT_V || ram_addr !== AB'(i)) begin
        n_fail++;
        $display("FAIL sweep_drive: cs %b we %h wd %h addr %h expected 1 ff %h %h",
                 ram_cs, ram_we, ram_wd, ram_addr, INIT_V, AB'(i));
      end
      n_cmp++;
      if (req_ready !== 1'b0 || init_done !== 1'b0 || dbg_state !== 1'b0) begin
        n_fail++;
        $display("FAIL sweep_status: ready %b done %b state %b expected 0 0 0", req_ready, init_done, dbg_state);
      end
    end
    @(posedge clk); #1;
    for (int i = 0; i < NW; i++) shadow[i] = INIT_V;
    exp_q.delete();
    resp_ready = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (init_done !== 1'b1 || req_ready !== 1'b1 || ram_cs !== 1'b0) begin
      n_fail++;
      $display("FAIL run_entry: done %b ready %b cs %b expected 1 1 0", init_done, req_ready, ram_cs);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_write_read();
    int a, t;
    do_req(4'd3, 8'hA5, 8'hFF, a);
    do_req(4'd3, 8'($urandom), 8'h00, t);
    @(negedge clk);
    n_cmp++;
    if (resp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL wr_rd_early: got valid %b expected 0 one cycle after accept", resp_valid);
    end
    @(negedge clk);
    n_cmp++;
    if (resp_valid !== 1'b1 || resp_rdata !== 8'hA5) begin
      n_fail++;
      $display("FAIL wr_rd_data: got valid %b data %h expected 1 a5", resp_valid, resp_rdata);
    end
    @(posedge clk); #1;
    wait_drain("wr_rd");
  endtask

  task automatic test_partial_mask();
    int a;
    bit seen;
    do_req(4'd5, 8'hFF, 8'hFF, a);
    do_req(4'd5, 8'h00, 8'h0F, a);
    do_req(4'd5, 8'h00, 8'h00, a);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (resp_valid) begin
        seen = 1'b1;
        n_cmp++;
        if (resp_rdata !== 8'hF0) begin
          n_fail++;
          $display("FAIL mask_data: got %h expected f0", resp_rdata);
        end
      end
    end
    if (!seen) begin
      n_cmp++; n_fail++;
      $display("FAIL mask_timeout: got no response expected one");
    end
    @(posedge clk); #1;
    wait_drain("mask");
  endtask

  task automatic test_backpressure();
    int acc, p0, tries;
    logic [DB-1:0] held;
    resp_ready = 1'b0;
    p0 = pop_cnt;
    acc = 0;
    req_valid = 1'b1; req_wmask = '0; req_wdata = '0; req_addr = AB'($urandom);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (req_ready) acc++;
      @(posedge clk); #1;
      if (req_ready === 1'b0 && acc == 0) begin end
      req_addr = (acc == 0) ? req_addr : AB'($urandom);
    end
    n_cmp++;
    if (acc != 4) begin
      n_fail++;
      $display("FAIL bp_accepts: got %0d expected 4", acc);
    end
    @(negedge clk);
    n_cmp++;
    if (req_ready !== 1'b0 || resp_valid !== 1'b1 || resp_rdata !== exp_q[0]) begin
      n_fail++;
      $display("FAIL bp_hold: ready %b valid %b data %h expected 0 1 %h", req_ready, resp_valid, resp_rdata, exp_q[0]);
    end
    held = resp_rdata;
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++;
    if (resp_rdata !== held || resp_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_stable: got %h valid %b expected %h 1", resp_rdata, resp_valid, held);
    end
    @(posedge clk); #1;
    resp_ready = 1'b1;
    tries = 0;
    while (acc < 6 && tries < 30) begin
      @(negedge clk);
      if (req_ready) acc++;
      @(posedge clk); #1;
      req_addr = AB'($urandom);
      tries++;
    end
    req_valid = 1'b0;
    wait_drain("bp");
    n_cmp++;
    if (acc != 6 || pop_cnt - p0 != 6) begin
      n_fail++;
      $display("FAIL bp_total: got %0d accepts %0d responses expected 6 6", acc, pop_cnt - p0);
    end
  endtask

  task automatic test_back_to_back();
    int c, first, last;
    resp_ready = 1'b1;
    pop_cyc_q.delete();
    first = -1;
    last = -1;
    for (int a = 0; a < 8; a++) begin
      do_req(AB'(a), 8'h00, 8'h00, c);
      if (a == 0) first = c;
      last = c;
    end
    n_cmp++;
    if (last - first != 7) begin
      n_fail++;
      $display("FAIL b2b_accept: got %0d cycles expected 8", last - first + 1);
    end
    wait_drain("b2b");
    n_cmp++;
    if (pop_cyc_q.size() != 8) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d responses expected 8", pop_cyc_q.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        n_cmp++;
        if (pop_cyc_q[i] != first + 2 + i) begin
          n_fail++;
          $display("FAIL b2b_timing: response %0d got cycle %0d expected %0d", i, pop_cyc_q[i], first + 2 + i);
        end
      end
    end
  endtask

  task automatic test_random();
    int c, reads, p0;
    logic [DB-1:0] m;
    reads = 0;
    p0 = pop_cnt;
    rand_rr = 1'b1;
    for (int k = 0; k < 150; k++) begin
      m = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom);
      if (m == '0) reads++;
      do_req(AB'($urandom), 8'($urandom), m, c);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
    end
    rand_rr = 1'b0;
    @(posedge clk); #2;
    resp_ready = 1'b1;
    wait_drain("rand");
    n_cmp++;
    if (pop_cnt - p0 != reads) begin
      n_fail++;
      $display("FAIL rand_count: got %0d responses expected %0d", pop_cnt - p0, reads);
    end
  endtask

  task automatic test_reset_mid();
    int c;
    resp_ready = 1'b0;
    do_req(AB'($urandom), 8'h00, 8'h00, c);
    do_req(AB'($urandom), 8'h00, 8'h00, c);
    mon_en = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (ram_cs !== 1'b0 || req_ready !== 1'b0 || resp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_hold: cs %b ready %b valid %b expected 0 0 0", ram_cs, req_ready, resp_valid);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < NW; i++) begin
      @(negedge clk);
      n_cmp++;
      if (ram_cs !== 1'b1 || ram_addr !== AB'(i) || resp_valid !== 1'b0 || init_done !== 1'b0) begin
        n_fail++;
        $display("FAIL midrst_sweep: cs %b addr %h valid %b done %b expected 1 %h 0 0",
                 ram_cs, ram_addr, resp_valid, init_done, AB'(i));
      end
    end
    @(posedge clk); #1;
    for (int i = 0; i < NW; i++) shadow[i] = INIT_V;
    exp_q.delete();
    resp_ready = 1'b1;
    mon_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_cmp++;
      if (resp_valid !== 1'b0 || init_done !== 1'b1) begin
        n_fail++;
        $display("FAIL midrst_stale: valid %b done %b expected 0 1", resp_valid, init_done);
      end
    end
    @(posedge clk); #1;
    do_req(4'd9, 8'h00, 8'h00, c);
    wait_drain("midrst");
  endtask

  initial begin
    for (int i = 0; i < NW; i++) ram_mem[i] = 8'($urandom);
    ram_rd_q = '0;
    test_reset();
    test_write_read();
    test_partial_mask();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1, "watchdog");
  end

endmodule
